mux_n_stream: RTL
=================

# mux_n_stream

Parametrised N-input, W-bit registered stream multiplexer that succeeds the two-input datapath mux. It selects one of `NUM_IN` valid/ready input channels, either by an explicit select or by round-robin arbitration, and presents the chosen beat on a single registered output with full throughput. It sits between multiple producers (e.g. writeback sources, memory/ALU result paths in multi-cycle variants) and one consumer.

## Interface
- `WIDTH`, 32, data width of each channel in bits (≥1)
- `NUM_IN`, 4, number of input channels (≥2)
- `MODE`, `MUX_FIXED`, arbitration mode (`MUX_FIXED` = select by `sel`, `MUX_RR` = round-robin)
- `SEL_W`, derived localparam = $clog2(NUM_IN), select/source index width
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_data`  in  NUM_IN×WIDTH  per-channel data
- `in_valid`  in  NUM_IN  per-channel valid
- `in_ready`  out  NUM_IN  per-channel ready (at most one bit high)
- `sel`  in  SEL_W  channel select, used only in `MUX_FIXED`
- `out_data`  out  WIDTH  registered selected data
- `out_valid`  out  1  registered output valid
- `out_ready`  in  1  consumer ready
- `out_src`  out  SEL_W  index of the channel that produced the held beat

## Operation
- Transfer on any channel occurs when valid and ready are both high on a rising edge.
- `load_en = !out_valid || out_ready` — output stage can accept a beat this cycle.
- Grant (combinational): `MUX_FIXED`: grant = `sel` if `sel < NUM_IN` and `in_valid[sel]`; `sel ≥ NUM_IN` → no grant. `MUX_RR`: first index with `in_valid` set, searching from `last_grant+1` upward with wrap to 0; none valid → no grant.
- `in_ready[i] = load_en && grant_valid && (i == grant)`; all other `in_ready` low.
- On a transfer: `out_data <= in_data[grant]`, `out_src <= grant`, `out_valid <= 1`; in `MUX_RR`, `last_grant <= grant`.
- No transfer and `out_ready` high: `out_valid <= 0`; `out_data`/`out_src` hold.
- `out_valid` high and `out_ready` low: `out_data`, `out_src`, `out_valid` hold; changes on `sel`/`in_valid` do not alter the held beat.
- `last_grant` updates only on an accepted input transfer; stalled cycles do not advance it.
- Reset values: `out_valid` 0, `out_data` 0, `out_src` 0, `last_grant` NUM_IN-1 (first RR search starts at channel 0). `in_ready` is 0 during reset.
- Reset mid-operation: held output beat is discarded; no input is accepted in the reset cycle.

## Timing
- Latency: 1 cycle from input transfer to `out_valid`.
- Throughput: 1 beat/cycle while `out_ready` held high (output drained and refilled in the same cycle).
- Combinational paths: `out_ready`, `in_valid`, `sel` → `in_ready`. No combinational path from inputs to `out_*`.
- RR fairness: with all channels continuously valid and `out_ready` high, grants cycle 0,1,…,NUM_IN-1,0 with no channel starved longer than NUM_IN-1 transfers.

## Structure
- Shared package `mux_pkg`: enum `mux_mode_e {MUX_FIXED, MUX_RR}`.
- Sub-module `rr_arbiter` (parameter `NUM_IN`): combinational rotating-priority grant from `req` and `last_grant`, outputs `grant` index and `grant_valid`. `last_grant` register lives in `mux_n_stream`.
- Output register and select logic live in `mux_n_stream`; `MODE` chosen with a generate branch.

## Test plan
- Reset: assert `rst` 2 cycles with all `in_valid`=1 → `out_valid`=0, `out_data`=0, `out_src`=0, all `in_ready`=0; first RR grant after release is channel 0.
- Fixed select, WIDTH=32, NUM_IN=4: `sel`=2, `in_data[2]`=0xDEADBEEF valid, `out_ready`=1 → `in_ready`=4'b0100, next cycle `out_data`=0xDEADBEEF, `out_src`=2, `out_valid`=1.
- Backpressure: beat 0x11 held with `out_ready`=0 for 3 cycles while `sel` switches 2→1 → `out_data` stays 0x11, `out_src` stays 2, all `in_ready`=0; `out_ready`=1 then loads channel 1 next cycle.
- Out-of-range select, NUM_IN=3: `sel`=3, all valid → no `in_ready`, `out_valid` drops to 0 after current beat drains.
- Round-robin, all 4 valid, `out_ready`=1 for 8 cycles → `out_src` sequence 0,1,2,3,0,1,2,3 with `out_valid` continuously 1.
- RR skip + stall: only channels 1 and 3 valid, `out_ready` toggling 1,0,1 → grants 1,3,1; `last_grant` unchanged across the stalled cycle.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types for the N-input stream multiplexer family.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mux_pkg;

  // Arbitration mode: MUX_FIXED follows the sel input, MUX_RR rotates fairly.
  typedef enum logic {
    MUX_FIXED = 1'b0,
    MUX_RR    = 1'b1
  } mux_mode_e;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority grant: first requester after last_grant, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; the caller qualifies the grant with its own load enable.
//
// Ports:
//   req         - per-channel request (in_valid of the mux)
//   last_grant  - index granted on the most recent accepted transfer
//   grant       - winning channel index (0 when grant_valid is low)
//   grant_valid - at least one channel is requesting
module rr_arbiter #(
  parameter  int NUM_IN = 4,
  localparam int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req,
  input  logic [SEL_W-1:0]  last_grant,
  output logic [SEL_W-1:0]  grant,
  output logic              grant_valid
);

  int w_cand;

  // Walk NUM_IN positions starting just after last_grant; the last position
  // visited is last_grant itself, so a lone requester can win repeatedly.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    w_cand      = 0;
    for (int k = 1; k <= NUM_IN; k++) begin
      w_cand = (int'(last_grant) + k) % NUM_IN;
      if (!grant_valid && req[w_cand]) begin
        grant       = w_cand[SEL_W-1:0];
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mux_n_stream.sv
// N-input valid/ready stream mux with a single registered output stage.
// Latency: 1 cycle from input transfer to out_valid; 1 beat/cycle sustained.
// Backpressure: out_ready low holds the output beat and drops every in_ready.
//
// Ports:
//   clk, rst   - clock and synchronous active-high reset
//   in_data    - NUM_IN x WIDTH channel data
//   in_valid   - per-channel valid
//   in_ready   - per-channel ready, one-hot or zero
//   sel        - channel select (MUX_FIXED only; values >= NUM_IN grant nothing)
//   out_data   - registered data of the held beat
//   out_valid  - registered valid of the held beat
//   out_ready  - consumer ready
//   out_src    - channel index that produced the held beat
module mux_n_stream
  import mux_pkg::*;
#(
  parameter  int        WIDTH  = 32,
  parameter  int        NUM_IN = 4,
  parameter  mux_mode_e MODE   = MUX_FIXED,
  localparam int        SEL_W  = $clog2(NUM_IN)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_IN-1:0][WIDTH-1:0]  in_data,
  input  logic [NUM_IN-1:0]             in_valid,
  output logic [NUM_IN-1:0]             in_ready,
  input  logic [SEL_W-1:0]              sel,
  output logic [WIDTH-1:0]              out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [SEL_W-1:0]              out_src
);

  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [SEL_W-1:0] r_out_src;

  logic [SEL_W-1:0] w_grant;
  logic             w_grant_vld;
  logic             w_load_en;
  logic             w_xfer;

  // The output stage can take a beat when empty or when it drains this cycle.
  assign w_load_en = !r_out_valid || out_ready;
  // Nothing is accepted in a reset cycle, so reset never loses an input beat.
  assign w_xfer    = !rst && w_load_en && w_grant_vld;

  generate
    if (MODE == MUX_RR) begin : g_rr
      logic [SEL_W-1:0] r_last_grant;
      logic             w_unused_sel;

      assign w_unused_sel = ^sel;

      rr_arbiter #(
        .NUM_IN (NUM_IN)
      ) u_arb (
        .req         (in_valid),
        .last_grant  (r_last_grant),
        .grant       (w_grant),
        .grant_valid (w_grant_vld)
      );

      // Reset to NUM_IN-1 so the first search starts at channel 0. Only an
      // accepted transfer moves the pointer; stalls leave priority intact.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_last_grant <= SEL_W'(NUM_IN - 1);
        end else if (w_xfer) begin
          r_last_grant <= w_grant;
        end
      end
    end else begin : g_fixed
      // Compare against each legal index rather than indexing in_valid with
      // sel directly, so an out-of-range sel cleanly yields no grant.
      always_comb begin
        w_grant     = sel;
        w_grant_vld = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
          if (int'(sel) == i) begin
            w_grant_vld = in_valid[i];
          end
        end
      end
    end
  endgenerate

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      in_ready[i] = w_xfer && (int'(w_grant) == i);
    end
  end

  // Load on transfer; otherwise a drained beat clears valid while data/src
  // keep their last value; a stalled beat holds everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_src   <= '0;
    end else if (w_xfer) begin
      r_out_data  <= in_data[w_grant];
      r_out_valid <= 1'b1;
      r_out_src   <= w_grant;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_src   = r_out_src;

endmodule
